// File: rtl/imem_loader.sv
// Boot loader for the instruction memory write port: takes a 16-bit word count, then a
// byte stream packed little-endian into 32-bit words, and holds the core in reset until done.
module imem_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              core_rst_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_DONE, S_ERR
    } state_e;

    // Largest legal word count (memory depth); a 16-bit count cannot exceed it once ADDR_W >= 16.
    localparam logic [16:0] MAX_CNT = (ADDR_W >= 16) ? 17'h10000 : 17'(32'd1 << ADDR_W);

    state_e            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       index_q, index_d;
    logic [1:0]        lane_q, lane_d;
    logic [2:0][7:0]   asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;

    logic              accept;
    logic [15:0]       cnt_full;

    assign byte_ready_o = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) || (state_q == S_DATA);
    assign accept       = byte_ready_o && byte_valid_i;
    assign cnt_full     = {byte_data_i, count_q[7:0]};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) state_d = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (accept) begin
                    count_d[7:0] = byte_data_i;
                    state_d      = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    count_d = cnt_full;
                    if (cnt_full == 16'd0 || {1'b0, cnt_full} > MAX_CNT) begin
                        state_d = S_ERR;
                    end else begin
                        index_d = '0;
                        lane_d  = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (lane_q != 2'd3) begin
                        asm_d[lane_q] = byte_data_i;
                        lane_d        = lane_q + 2'd1;
                    end else begin
                        // Output word lives in its own register so the next lane-0 byte can land now.
                        data_d = {byte_data_i, asm_q};
                        addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(index_q);
                        we_d   = 1'b1;
                        lane_d = '0;
                        if (index_q == count_q - 16'd1) begin
                            state_d = S_DONE;
                        end else begin
                            index_d = index_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            index_q <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign imem_we_o   = we_q;
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign core_rst_o  = (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 4095) share stimulus; expected
// writes are queued as bytes are sent and checked when imem_we_o fires.
module tb_imem_loader;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        bvalid = 1'b0;
    logic [7:0]  bdata = 8'h00;
    logic [1:0]  ready, we, crst, done, err;
    logic [11:0] addr [2];
    logic [31:0] data [2];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          we_cyc[$];
    exp_t        sb[2][$];
    exp_t        e;
    logic [31:0] img[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    imem_loader #(.ADDR_W(12), .BASE_ADDR(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .byte_valid_i(bvalid), .byte_data_i(bdata),
        .byte_ready_o(ready[0]), .imem_we_o(we[0]), .imem_addr_o(addr[0]), .imem_data_o(data[0]),
        .core_rst_o(crst[0]), .done_o(done[0]), .err_o(err[0])
    );

    imem_loader #(.ADDR_W(12), .BASE_ADDR(4095)) u_wrap (
        .clk_i(clk), .rst_i(rst), .start_i(start), .byte_valid_i(bvalid), .byte_data_i(bdata),
        .byte_ready_o(ready[1]), .imem_we_o(we[1]), .imem_addr_o(addr[1]), .imem_data_o(data[1]),
        .core_rst_o(crst[1]), .done_o(done[1]), .err_o(err[1])
    );

    // Scoreboard: every write strobe must match the oldest queued word.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (we[k] === 1'b1) begin
                total++;
                if (k == 1) we_cyc.push_back(cyc);
                if (sb[k].size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write dut%0d: got addr=%h data=%h, expected no write",
                             k, addr[k], data[k]);
                end else begin
                    e = sb[k].pop_front();
                    if (addr[k] !== e.addr || data[k] !== e.data) begin
                        bad++;
                        $display("FAIL write dut%0d: got addr=%h data=%h, expected addr=%h data=%h",
                                 k, addr[k], data[k], e.addr, e.data);
                    end
                    total++;
                    if (done[k] !== e.last || crst[k] !== !e.last) begin
                        bad++;
                        $display("FAIL done_at_write dut%0d: got done=%b core_rst=%b, expected done=%b core_rst=%b",
                                 k, done[k], crst[k], e.last, !e.last);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
        int n;
        bvalid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            start = st && (i == 0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        bvalid = 1'b1;
        bdata  = b;
        n = 0;
        while (ready[0] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (ready[0] !== 1'b1) begin
            total++; bad++;
            $display("FAIL ready_timeout: got byte_ready_o=%b, expected 1 within 20 cycles", ready[0]);
        end
        @(posedge clk); #1;
        bvalid = 1'b0;
    endtask

    task automatic push_word(input int w, input int n);
        sb[0].push_back('{addr: 12'(w), data: img[w], last: (w == n - 1)});
        sb[1].push_back('{addr: 12'(4095 + w), data: img[w], last: (w == n - 1)});
    endtask

    task automatic load(input int n, input bit gaps, input bit mid_start);
        int g;
        logic [15:0] cnt;
        cnt = 16'(n);
        pulse_start();
        total++;
        if (ready !== 2'b11 || crst !== 2'b11 || done !== 2'b00) begin
            bad++;
            $display("FAIL after_start: got ready=%b core_rst=%b done=%b, expected 11 11 00", ready, crst, done);
        end
        send_byte(cnt[7:0], 0, 0);
        send_byte(cnt[15:8], 0, 0);
        for (int w = 0; w < n; w++) begin
            push_word(w, n);
            for (int b = 0; b < 4; b++) begin
                g = gaps ? $urandom_range(0, 3) : 0;
                if (mid_start && b == 1) g = g + 1;
                send_byte(img[w][8*b +: 8], g, mid_start && b == 1);
            end
        end
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ready[k] !== 1'b0 || we[k] !== 1'b0 || addr[k] !== 12'h0 || data[k] !== 32'h0 ||
                crst[k] !== 1'b1 || done[k] !== 1'b0 || err[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d: got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b, expected 0 0 000 0 1 0 0",
                         k, ready[k], we[k], addr[k], data[k], crst[k], done[k], err[k]);
            end
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic check_done(input string name);
        total++;
        if (done !== 2'b11 || crst !== 2'b00 || ready !== 2'b00 || err !== 2'b00) begin
            bad++;
            $display("FAIL %s: got done=%b core_rst=%b ready=%b err=%b, expected 11 00 00 00",
                     name, done, crst, ready, err);
        end
    endtask

    task automatic test_basic();
        img[0] = 32'h00000013;
        img[1] = 32'h00108093;
        load(2, 0, 0);
        check_done("basic_done");
    endtask

    task automatic test_wrap_back_to_back();
        img[0] = 32'hdeadbeef;
        img[1] = 32'h01234567;
        we_cyc.delete();
        load(2, 0, 0);
        total++;
        if (we_cyc.size() != 2 || we_cyc[1] - we_cyc[0] != 4) begin
            bad++;
            $display("FAIL we_spacing: got %0d strobes spacing=%0d, expected 2 strobes spacing=4",
                     we_cyc.size(), (we_cyc.size() == 2) ? we_cyc[1] - we_cyc[0] : -1);
        end
        check_done("wrap_done");
    endtask

    task automatic check_err(input string name);
        total++;
        if (err !== 2'b11 || crst !== 2'b11 || ready !== 2'b00 || done !== 2'b00) begin
            bad++;
            $display("FAIL %s: got err=%b core_rst=%b ready=%b done=%b, expected 11 11 00 00",
                     name, err, crst, ready, done);
        end
    endtask

    task automatic test_err();
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h00, 0, 0);
        check_err("err_zero");
        // bytes offered in ERR must be ignored
        bvalid = 1'b1; bdata = 8'h55;
        tick(3);
        bvalid = 1'b0;
        check_err("err_hold");
        pulse_start();
        send_byte(8'h01, 0, 0);
        send_byte(8'h10, 0, 0);
        check_err("err_4097");
        // count 4096 is the largest legal size
        pulse_start();
        send_byte(8'h00, 0, 0);
        send_byte(8'h10, 0, 0);
        total++;
        if (err !== 2'b00 || ready !== 2'b11) begin
            bad++;
            $display("FAIL count_4096: got err=%b ready=%b, expected 00 11", err, ready);
        end
        #3 rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int w = 0; w < 3; w++) img[w] = $urandom;
        load(3, 0, 0);
        check_done("err_recover");
    endtask

    task automatic test_gaps();
        for (int w = 0; w < 16; w++) img[w] = $urandom;
        load(16, 0, 0);
        check_done("gapfree_done");
        load(16, 1, 1);
        check_done("gaps_done");
    endtask

    task automatic test_rst_mid();
        logic [15:0] cnt;
        for (int w = 0; w < 8; w++) img[w] = $urandom;
        cnt = 16'd8;
        pulse_start();
        send_byte(cnt[7:0], 0, 0);
        send_byte(cnt[15:8], 0, 0);
        for (int w = 0; w < 3; w++) begin
            push_word(w, 8);
            for (int b = 0; b < 4; b++) send_byte(img[w][8*b +: 8], 0, 0);
        end
        send_byte(img[3][7:0], 0, 0);
        send_byte(img[3][15:8], 0, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (ready[k] !== 1'b0 || we[k] !== 1'b0 || addr[k] !== 12'h0 || data[k] !== 32'h0 ||
                crst[k] !== 1'b1 || done[k] !== 1'b0 || err[k] !== 1'b0) begin
                bad++;
                $display("FAIL async_reset dut%0d: got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b, expected 0 0 000 0 1 0 0",
                         k, ready[k], we[k], addr[k], data[k], crst[k], done[k], err[k]);
            end
        end
        tick(3);
        rst = 1'b0;
        tick(1);
        load(8, 0, 0);
        check_done("rst_mid_reload");
    endtask

    task automatic test_restart_from_done();
        for (int w = 0; w < 4; w++) img[w] = ~img[w];
        load(4, 1, 0);
        check_done("restart_done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_back_to_back();
        test_err();
        test_gaps();
        test_rst_mid();
        test_restart_from_done();
        tick(4);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (sb[k].size() != 0) begin
                bad++;
                $display("FAIL missing_writes dut%0d: got %0d outstanding, expected 0", k, sb[k].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
